// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner
// Three-digit multiplexed 7-segment driver for a packed BCD value (000-255).
// A value loaded mid-frame is held in a pending register and copied to the
// display register only at a frame boundary. This keeps one frame from
// mixing digits of two different values.
// Scan order is units, tens, hundreds. Leading zeros can be blanked, and
// nibbles above 9 show a dash. Segment and anode outputs are registered
// and share one polarity.
module bcd_display_scanner #(
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd,
    input  logic        load,
    input  logic        blank_lz,
    input  logic        en,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        frame_done
);

    localparam int             CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0]     AN_OFF   = ACTIVE_LOW ? 3'b111 : 3'b000;

    // Active-high {g,f,e,d,c,b,a} pattern for one BCD nibble. Codes above 9 show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [11:0]   pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic [11:0]   disp_q, disp_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;
    logic          frame_done_q, frame_done_d;

    logic          tick;
    logic          frame_edge;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    digit_seg;
    logic [2:0]    an_raw;

    // Prescaler and digit index. Both hold while scanning is disabled.
    always_comb begin
        tick       = en && (cnt_q == CNT_LAST);
        frame_edge = tick && (idx_q == 2'd2);
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
        if (tick) begin
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
    end

    // Double buffer. A load on the boundary cycle itself bypasses the pending register.
    always_comb begin
        disp_d   = disp_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        if (frame_edge) begin
            if (load) begin
                disp_d = bcd;
            end else if (pend_v_q) begin
                disp_d = pend_q;
            end
            pend_v_d = 1'b0;
        end else if (load) begin
            pend_d   = bcd;
            pend_v_d = 1'b1;
        end
    end

    // Digit select, leading-zero blanking, decode and output polarity.
    // An invalid nibble is nonzero, so it never triggers blanking.
    always_comb begin
        nib    = disp_q[3:0];
        blank  = 1'b0;
        an_raw = 3'b001;
        case (idx_q)
            2'd1: begin
                nib    = disp_q[7:4];
                blank  = blank_lz && (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
                an_raw = 3'b010;
            end
            2'd2: begin
                nib    = disp_q[11:8];
                blank  = blank_lz && (disp_q[11:8] == 4'd0);
                an_raw = 3'b100;
            end
            default: begin
                nib    = disp_q[3:0];
                blank  = 1'b0;
                an_raw = 3'b001;
            end
        endcase
        digit_seg    = blank ? 7'h00 : seg_decode(nib);
        seg_d        = SEG_OFF;
        an_d         = AN_OFF;
        frame_done_d = frame_edge;
        if (en) begin
            seg_d = digit_seg ^ {7{ACTIVE_LOW}};
            an_d  = an_raw ^ {3{ACTIVE_LOW}};
        end
    end

    // State and output registers. Reset leaves the display dark at the active polarity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            pend_q       <= 12'h000;
            pend_v_q     <= 1'b0;
            disp_q       <= 12'h000;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            disp_q       <= disp_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Time-multiplexed 3-digit 7-segment display driver that sits directly downstream of the byte-to-BCD converter in the servo controller. It shows servo position or command values as 000–255. It captures a 12-bit packed BCD word on a load strobe and double-buffers it so the display only changes on frame boundaries. It then scans units, tens and hundreds digits with registered segment and anode outputs, blanks leading zeros, and flags invalid nibbles.

## Interface
- REFRESH_DIV, 50000: clock cycles each digit stays lit. Must be ≥2. The prescaler is $clog2(REFRESH_DIV) bits wide.
- ACTIVE_LOW, 1: when 1, `seg` and `an` are inverted at the output (common-anode board). When 0, both are active-high.
- clk  in  1  system clock. One clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- bcd  in  12  packed BCD: [11:8] hundreds, [7:4] tens, [3:0] units.
- load  in  1  1-cycle strobe that captures `bcd` into the pending register.
- blank_lz  in  1  enables leading-zero blanking. Sampled every cycle.
- en  in  1  scan enable.
- seg  out  7  {g,f,e,d,c,b,a}, registered.
- an  out  3  one-hot digit enable. an[0] is units, an[2] is hundreds. Registered.
- frame_done  out  1  1-cycle pulse at each frame boundary.

## Operation
- Registers:
  - prescaler `cnt`
  - digit index `idx` (0..2)
  - pending register `pend` (12 bits) and flag `pend_v`
  - display register `disp`
  - output registers
- Prescaler behaviour:
  - When en=1, `cnt` counts 0..REFRESH_DIV-1 and wraps.
  - `tick` = en && cnt==REFRESH_DIV-1.
  - On `tick`, `idx` advances 0→1→2→0.
- Frame boundary = `tick` with idx==2. On that edge:
  - `frame_done` is 1 for one cycle.
  - If load=1 in that same cycle, disp ← bcd. Otherwise, if pend_v, disp ← pend.
  - pend_v ← 0.
- Load outside a boundary: pend ← bcd and pend_v ← 1. The last load before a boundary wins.
- Digit decode for nibble n (pre-polarity):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - n>9 shows a dash, 40.
  - Blank is 00.
- Leading-zero blanking, when blank_lz=1:
  - Hundreds is blank if disp[11:8]==0.
  - Tens is blank if disp[11:8]==0 and disp[7:4]==0.
  - Units are never blanked.
  - An invalid nibble counts as nonzero.
- Outputs:
  - an ← onehot(idx).
  - seg ← decode(disp nibble[idx]) after blanking.
  - ACTIVE_LOW inversion is applied last.
- en=0:
  - `cnt`, `idx` and `disp` are held.
  - The next edge drives an and seg to the all-off pattern and frame_done=0.
  - Loads into `pend` still occur, but no boundary occurs.
  - When en returns to 1, scanning resumes from the held `cnt`/`idx`.

## Timing
- Reset (asynchronous, any time, including mid-frame):
  - cnt=0, idx=0, disp=0, pend=0, pend_v=0, frame_done=0.
  - an and seg are all-off: 000/00 active-high, 111/7F active-low.
- First clock edge after rst_n rises, with en=1: an=001 and seg=decode(0)=3F.
- Output latency: an/seg lag `idx` by one clock. Each digit is lit for exactly REFRESH_DIV cycles. A full frame is 3·REFRESH_DIV cycles.
- frame_done asserts on the same edge that idx goes 2→0. The new `disp` appears on seg starting with the units digit, one clock later.
- Load-to-display latency: at most 3·REFRESH_DIV+1 cycles. Intermediate values never appear mid-frame, so there is no tearing.

## Test plan
All scenarios use REFRESH_DIV=4 and ACTIVE_LOW=0.
- **Reset then run:** release rst_n with en=1 and no load → the bench sees an=001/seg=3F, then an=010/seg=3F, then an=100/seg=3F, 4 cycles each. frame_done pulses every 12 cycles. Assert rst_n low mid-frame → an=000 and seg=00 immediately.
- **Load 180, blank_lz=1:** load bcd=0x180 → after the next frame_done the bench sees units 3F, tens 7F, hundreds 06.
- **Leading zeros, bcd=0x007:** with blank_lz=1 → 07, 00, 00. With blank_lz=0 → 07, 3F, 3F.
- **Double buffering:** with disp=0x111, load 0x045 then 0x099 during digit 1 of the same frame → the current frame still shows 06/06/06, and the next frame shows 6F/6F/3F.
- **Load coincident with a frame boundary:** load 0x255 on the frame_done cycle → the following frame shows 6D/6D/5B.
- **Invalid nibble and enable gating:** load 0x1A5 → 6D, 40, 06. Drop en for 10 cycles mid-digit → an=000 from the next edge. After en returns, the remaining dwell of that digit resumes, with no extra frame_done.
